// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_pkg
//  Purpose  : Shared definitions for the instruction fetch unit: FSM state
//             encoding, default reset PC, handshake widths and a PC alignment
//             helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ifu_fetch_pkg;

  // Fetch FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          IMEM_ADDR_W      = 32;
  localparam int          IMEM_DATA_W      = 32;

  // A fetch address is legal only when word aligned.
  function automatic logic pc_aligned(input logic [IMEM_ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Purpose  : Architectural program counter register with load enable.
//  Ports    : clk    in   clock, rising edge
//             rst_n  in   asynchronous active-low reset (loads RESET_PC)
//             load   in   load d into the register
//             d      in   next PC value
//             q      out  current PC
//  Revision : 1.0  initial release
// ============================================================================
module pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [IMEM_ADDR_W-1:0] d,
  output logic [IMEM_ADDR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction fetch unit. Holds the PC, fetches the word at PC
//             over a req/ready + rvalid handshake (one fetch outstanding),
//             presents it to decode and loads npc when the instruction
//             retires. A misaligned npc traps into a sticky fault/halt.
//  Ports    : clk, rst_n                     clock / async active-low reset
//             pc          out 32             current PC (drives npc.pc)
//             npc         in  32             next PC from npc block
//             pc_advance  in  1              retire: load npc into pc
//             imem_req/imem_addr  out        fetch request / address (= pc)
//             imem_ready  in                 memory accepts request
//             imem_rvalid/imem_rdata  in     read response
//             instr/instr_valid  out         fetched word and its valid
//             fault       out                sticky misaligned-npc trap
//             fetch_count out CNT_W          completed fetches (wrapping)
//  Revision : 1.0  initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_ADDR_W-1:0] pc,
  input  logic [IMEM_ADDR_W-1:0] npc,
  input  logic                   pc_advance,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [IMEM_DATA_W-1:0] imem_rdata,
  output logic [IMEM_DATA_W-1:0] instr,
  output logic                   instr_valid,
  output logic                   fault,
  output logic [CNT_W-1:0]       fetch_count
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic capture;     // response accepted this cycle
  logic retire_ok;   // retire with an aligned npc
  logic retire_bad;  // retire with a misaligned npc

  assign capture    = (state == S_WAIT) && imem_rvalid;
  assign retire_ok  = (state == S_HOLD) && pc_advance &&  pc_aligned(npc);
  assign retire_bad = (state == S_HOLD) && pc_advance && !pc_aligned(npc);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (retire_ok),
    .d     (npc),
    .q     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (imem_ready) state_nxt = S_WAIT;
      S_WAIT: if (imem_rvalid) state_nxt = S_HOLD;
      S_HOLD: begin
        if (retire_ok)  state_nxt = S_REQ;
        if (retire_bad) state_nxt = S_HALT;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request and valid decode straight from the state register so they
  // never glitch on input changes.
  assign imem_req    = (state == S_REQ);
  assign instr_valid = (state == S_HOLD);
  assign imem_addr   = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      fetch_count <= '0;
      fault       <= 1'b0;
    end else begin
      if (capture) begin
        instr       <= imem_rdata;
        fetch_count <= fetch_count + 1'b1;
      end
      if (retire_bad) begin
        fault <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch
//  Purpose  : Self-checking bench for ifu_fetch. Acts as instruction memory
//             with random ready/rvalid latencies and checks every observable
//             output against a transaction-level model of the fetch loop.
//             A 4-bit fetch counter makes the counter wrap occur naturally.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

  localparam int          CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      pc;
  logic [31:0]      npc;
  logic             pc_advance;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC (RPC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .npc         (npc),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  int unsigned exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
    return 32'(exp_cnt % (1 << CNT_W));
  endfunction

  function automatic logic [31:0] rand_aligned();
    logic [31:0] v;
    v = $urandom;
    return v & 32'hFFFF_FFFC;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously mid-cycle and check it takes effect at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc",    pc,                  RPC);
    check("rst_instr", instr,               32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_req",   {31'h0, imem_req},    32'h0);
    check("rst_fault", {31'h0, fault},       32'h0);
    check("rst_cnt",   32'(fetch_count),     32'h0);
    tick();
    tick();
    rst_n     = 1'b1;
    exp_pc    = RPC;
    exp_cnt   = 0;
    exp_instr = 32'h0;
    check("idle_req", {31'h0, imem_req}, 32'h0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("req_seen", {31'h0, imem_req}, 32'h1);
  endtask

  // One complete fetch: rdy_dly stall cycles, rv_dly response latency.
  task automatic fetch(input logic [31:0] data, input int rdy_dly, input int rv_dly, input bit inject);
    wait_req();
    check("addr", imem_addr, exp_pc);
    check("pc",   pc,        exp_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = inject ? 1'($urandom % 2) : 1'b0;
      imem_rdata  = $urandom;
      tick();
      check("stall_req",   {31'h0, imem_req},    32'h1);
      check("stall_addr",  imem_addr,            exp_pc);
      check("stall_valid", {31'h0, instr_valid}, 32'h0);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    tick();
    check("req_drop",   {31'h0, imem_req},    32'h0);
    check("wait_valid", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < rv_dly; i++) begin
      imem_ready  = 1'($urandom % 2);
      imem_rvalid = 1'b0;
      tick();
      check("wait_req",   {31'h0, imem_req},    32'h0);
      check("wait_valid", {31'h0, instr_valid}, 32'h0);
    end
    imem_ready  = 1'($urandom % 2);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = $urandom;
    exp_cnt++;
    exp_instr = data;
    check("instr",     instr,                 data);
    check("valid",     {31'h0, instr_valid},  32'h1);
    check("count",     32'(fetch_count),      cnt_exp());
    check("hold_req",  {31'h0, imem_req},     32'h0);
  endtask

  // Hold the instruction for a few cycles, then retire it with npc = nxt.
  task automatic retire(input logic [31:0] nxt, input int hold);
    for (int i = 0; i < hold; i++) begin
      pc_advance  = 1'b0;
      npc         = $urandom;
      imem_rvalid = 1'($urandom % 2);
      imem_ready  = 1'($urandom % 2);
      imem_rdata  = $urandom;
      tick();
      check("hold_instr", instr,                 exp_instr);
      check("hold_valid", {31'h0, instr_valid},  32'h1);
      check("hold_req",   {31'h0, imem_req},     32'h0);
      check("hold_pc",    pc,                    exp_pc);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    npc         = nxt;
    pc_advance  = 1'b1;
    tick();
    pc_advance = 1'b0;
    check("adv_valid", {31'h0, instr_valid}, 32'h0);
    if (nxt[1:0] == 2'b00) begin
      exp_pc = nxt;
      check("adv_pc",    pc,                exp_pc);
      check("adv_req",   {31'h0, imem_req}, 32'h1);
      check("adv_addr",  imem_addr,         exp_pc);
      check("adv_fault", {31'h0, fault},    32'h0);
    end else begin
      check("trap_fault", {31'h0, fault},    32'h1);
      check("trap_pc",    pc,                exp_pc);
      check("trap_req",   {31'h0, imem_req}, 32'h0);
      for (int i = 0; i < 6; i++) begin
        pc_advance  = 1'($urandom % 2);
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        npc         = rand_aligned();
        tick();
        check("halt_req",   {31'h0, imem_req},    32'h0);
        check("halt_fault", {31'h0, fault},       32'h1);
        check("halt_pc",    pc,                   exp_pc);
        check("halt_valid", {31'h0, instr_valid}, 32'h0);
      end
      pc_advance  = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    npc         = 32'h0;
    pc_advance  = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    exp_pc      = RPC;
    exp_cnt     = 0;
    exp_instr   = 32'h0;
    tick();

    // Reset release with memory always ready: request one cycle later.
    imem_ready = 1'b1;
    do_reset();
    tick();
    check("t1_req_rise", {31'h0, imem_req}, 32'h1);
    check("t1_addr",     imem_addr,         RPC);
    fetch(32'h2001_0005, 0, 0, 1'b0);

    // Sequential advance, then a taken branch.
    retire(32'h0000_3004, 1);
    fetch($urandom, 0, 1, 1'b0);
    retire(32'h0000_3010, 2);

    // Long ready stall with stray rvalid pulses while requesting.
    fetch(32'hCAFE_0001, 5, 2, 1'b1);
    retire(32'hFFFF_FFFC, 0);
    fetch($urandom, 1, 0, 1'b0);
    retire(32'h0000_0000, 1);

    // Random traffic; more than 16 fetches wraps the 4-bit counter.
    for (int k = 0; k < 24; k++) begin
      fetch($urandom, int'($urandom % 4), int'($urandom % 3), 1'($urandom % 2));
      retire(rand_aligned(), int'($urandom % 3));
    end

    // Misaligned npc traps and halts.
    fetch($urandom, 0, 0, 1'b0);
    retire(exp_pc + 32'd6 | 32'h2, 1);

    // Reset out of the halt, then reset while waiting for a response.
    do_reset();
    wait_req();
    check("t5_addr", imem_addr, RPC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("t5_in_wait", {31'h0, imem_req}, 32'h0);
    do_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    check("t5_valid", {31'h0, instr_valid}, 32'h0);
    check("t5_req",   {31'h0, imem_req},    32'h1);
    check("t5_addr2", imem_addr,            RPC);
    tick();
    check("t5_stale", instr,                32'h0);
    check("t5_cnt",   32'(fetch_count),     32'h0);
    imem_rvalid = 1'b0;
    fetch(32'h1234_5678, 0, 0, 1'b0);
    retire(32'h0000_3004, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
